// File: rtl/bmem_pkg.sv
// Shared definitions for the 4-beat x 64-bit bmem burst protocol.
// The cache-side adapter and the memory-side responder both use these.
package bmem_pkg;

    localparam int BMEM_BEATS    = 4;
    localparam int BMEM_BEAT_W   = 64;
    localparam int BMEM_LINE_W   = 256;
    localparam int BMEM_OFFSET_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_READ_WAIT  = 2'd2,
        ST_READ_BURST = 2'd3
    } bmem_resp_state_t;

    typedef logic [BMEM_LINE_W-1:0] bmem_line_t;

    // Select beat k (bits [64k+63:64k]) of a line.
    function automatic logic [BMEM_BEAT_W-1:0] bmem_beat(input bmem_line_t line,
                                                         input logic [1:0] beat);
        return line[{beat, 6'd0} +: BMEM_BEAT_W];
    endfunction

endpackage

// File: rtl/bmem_line_ram.sv
// Line store for the bmem responder: NUM_LINES x 256-bit array with one
// 64-bit beat-write port and one asynchronous whole-line read port.
// Contents are deliberately not reset.
module bmem_line_ram
    import bmem_pkg::*;
#(
    parameter int NUM_LINES = 256,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [IDX_W-1:0]       wr_idx_i,
    input  logic [1:0]             wr_beat_i,
    input  logic [BMEM_BEAT_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]       rd_idx_i,
    output bmem_line_t             rd_line_o
);

    bmem_line_t mem_q [NUM_LINES];

    // Write one 64-bit beat into the selected line.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx_i][{wr_beat_i, 6'd0} +: BMEM_BEAT_W] <= wr_data_i;
        end
    end

    assign rd_line_o = mem_q[rd_idx_i];

endmodule

// File: rtl/bmem_burst_responder.sv
// Memory-side responder for 4-beat x 64-bit bmem bursts.
// Reads return 4 beats READ_LATENCY cycles after the request; writes take
// 4 consecutive beats. err is a sticky protocol-violation flag.
// Optional: define BMEM_RESP_RADDR_EN to add bmem_raddr, the line-aligned
// request address shown alongside each read beat.
module bmem_burst_responder
    import bmem_pkg::*;
#(
    parameter int NUM_LINES    = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            bmem_addr,
    input  logic                   bmem_read,
    input  logic                   bmem_write,
    input  logic [BMEM_BEAT_W-1:0] bmem_wdata,
    output logic                   bmem_ready,
    output logic [BMEM_BEAT_W-1:0] bmem_rdata,
    output logic                   bmem_rvalid,
`ifdef BMEM_RESP_RADDR_EN
    output logic [31:0]            bmem_raddr,
`endif
    output logic                   err
);

    localparam int IDX_W    = $clog2(NUM_LINES);
    // Wait counter only needs to hold READ_LATENCY-2.
    localparam int LAT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam int LAT_LOAD = (READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0;

    bmem_resp_state_t       state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    bmem_line_t             line_q, line_d;
    logic [BMEM_BEAT_W-1:0] rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;

    logic                   we_s;
    logic [IDX_W-1:0]       wr_idx_s;
    logic [1:0]             wr_beat_s;
    logic [IDX_W-1:0]       req_idx_s;
    logic [IDX_W-1:0]       rd_idx_s;
    bmem_line_t             rd_line_s;

    assign req_idx_s = bmem_addr[BMEM_OFFSET_W +: IDX_W];
    // A burst is entered either straight from IDLE (latency 1) or from
    // READ_WAIT, so the read port follows the live request only in IDLE.
    assign rd_idx_s  = (state_q == ST_IDLE) ? req_idx_s : idx_q;

    bmem_line_ram #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (we_s),
        .wr_idx_i  (wr_idx_s),
        .wr_beat_i (wr_beat_s),
        .wr_data_i (bmem_wdata),
        .rd_idx_i  (rd_idx_s),
        .rd_line_o (rd_line_s)
    );

    // Next-state, beat/latency counters, write port control and output next values.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        line_d    = line_q;
        rdata_d   = '0;
        rvalid_d  = 1'b0;
        err_d     = err_q;
        we_s      = 1'b0;
        wr_idx_s  = idx_q;
        wr_beat_s = cnt_q;
        if (rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!ready_q) begin
                        // First cycle out of reset: not yet advertising ready.
                        if (bmem_read || bmem_write) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end else if (bmem_write) begin
                        idx_d     = req_idx_s;
                        we_s      = 1'b1;
                        wr_idx_s  = req_idx_s;
                        wr_beat_s = 2'd0;
                        cnt_d     = 2'd1;
                        state_d   = ST_WRITE;
                        if (bmem_read) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end else if (bmem_read) begin
                        idx_d = req_idx_s;
                        if (READ_LATENCY == 1) begin
                            line_d   = rd_line_s;
                            rdata_d  = bmem_beat(rd_line_s, 2'd0);
                            rvalid_d = 1'b1;
                            cnt_d    = 2'd1;
                            state_d  = ST_READ_BURST;
                        end else begin
                            lat_d   = LAT_W'(LAT_LOAD);
                            state_d = ST_READ_WAIT;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (bmem_read) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (bmem_write) begin
                        we_s  = 1'b1;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end else begin
                        // Truncated burst: beats already written are kept.
                        err_d   = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = ST_IDLE;
                    end
                end
                ST_READ_WAIT: begin
                    if (bmem_read || bmem_write) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (lat_q == '0) begin
                        line_d   = rd_line_s;
                        rdata_d  = bmem_beat(rd_line_s, 2'd0);
                        rvalid_d = 1'b1;
                        cnt_d    = 2'd1;
                        state_d  = ST_READ_BURST;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                ST_READ_BURST: begin
                    if (bmem_read || bmem_write) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    // cnt_q is the next beat to present; 0 means beat 3 is on the bus.
                    if (cnt_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d  = bmem_beat(line_q, cnt_q);
                        rvalid_d = 1'b1;
                        cnt_d    = cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        ready_d = (state_d == ST_IDLE) || (state_d == ST_WRITE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= 2'd0;
            lat_q    <= '0;
            line_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            line_q   <= line_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign bmem_ready  = ready_q;
    assign bmem_rdata  = rdata_q;
    assign bmem_rvalid = rvalid_q;
    assign err         = err_q;

`ifdef BMEM_RESP_RADDR_EN
    logic [31-BMEM_OFFSET_W:0] addr_q, addr_d;
    logic [31:0]               raddr_q, raddr_d;
    logic                      unused_addr_s;

    assign unused_addr_s = ^bmem_addr[BMEM_OFFSET_W-1:0];

    // Capture the request line address on read accept; show it with each beat.
    always_comb begin
        if ((state_q == ST_IDLE) && ready_q && bmem_read && !bmem_write && !rst) begin
            addr_d = bmem_addr[31:BMEM_OFFSET_W];
        end else begin
            addr_d = addr_q;
        end
        if (rvalid_d) begin
            raddr_d = {addr_d, {BMEM_OFFSET_W{1'b0}}};
        end else begin
            raddr_d = 32'd0;
        end
    end

    // Request address and bmem_raddr registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            raddr_q <= 32'd0;
        end else begin
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
        end
    end

    assign bmem_raddr = raddr_q;
`else
    logic unused_addr_s;

    assign unused_addr_s = ^bmem_addr;
`endif

endmodule

// File: tb/tb_bmem_burst_responder.sv
// Directed bench for bmem_burst_responder. dut0 uses READ_LATENCY=2 and is
// driven from a per-cycle vector table; dut1 (READ_LATENCY=1) shares the
// same inputs and is checked by a hand-written back-to-back read sequence.
module tb_bmem_burst_responder;

    logic        clk = 1'b0;
    logic        rst, rd, wr;
    logic [31:0] addr;
    logic [63:0] wdata;

    logic        ready0, rvalid0, err0, ready1, rvalid1, err1;
    logic [63:0] rdata0, rdata1;
`ifdef BMEM_RESP_RADDR_EN
    logic [31:0] raddr0, raddr1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bmem_burst_responder #(.NUM_LINES(256), .READ_LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .bmem_addr(addr), .bmem_read(rd), .bmem_write(wr),
        .bmem_wdata(wdata), .bmem_ready(ready0), .bmem_rdata(rdata0),
        .bmem_rvalid(rvalid0),
`ifdef BMEM_RESP_RADDR_EN
        .bmem_raddr(raddr0),
`endif
        .err(err0)
    );

    bmem_burst_responder #(.NUM_LINES(256), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bmem_addr(addr), .bmem_read(rd), .bmem_write(wr),
        .bmem_wdata(wdata), .bmem_ready(ready1), .bmem_rdata(rdata1),
        .bmem_rvalid(rvalid1),
`ifdef BMEM_RESP_RADDR_EN
        .bmem_raddr(raddr1),
`endif
        .err(err1)
    );

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        ready, rvalid;
        logic [63:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] A1 = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] B1 = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] C1 = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] D1 = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [63:0] O0 = 64'h5000_0000_0000_0000;
    localparam logic [63:0] O1 = 64'h5000_0000_0000_0001;
    localparam logic [63:0] O2 = 64'h5000_0000_0000_0002;
    localparam logic [63:0] O3 = 64'h5000_0000_0000_0003;
    localparam logic [63:0] N0 = 64'hEEEE_EEEE_EEEE_0000;
    localparam logic [63:0] N1 = 64'hEEEE_EEEE_EEEE_0001;

    task automatic add(input logic r, input logic rq, input logic wq, input logic [31:0] a,
                       input logic [63:0] d, input logic e_ready, input logic e_rvalid,
                       input logic [63:0] e_rdata, input logic e_err);
        vec_t v;
        v.rst = r; v.rd = rq; v.wr = wq; v.addr = a; v.wdata = d;
        v.ready = e_ready; v.rvalid = e_rvalid; v.rdata = e_rdata; v.err = e_err;
        tbl.push_back(v);
    endtask

    // Apply inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic drive(input logic r, input logic rq, input logic wq,
                         input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        rst = r; rd = rq; wr = wq; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input string f, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int which, input logic e_ready,
                       input logic e_rvalid, input logic [63:0] e_rdata, input logic e_err);
        logic        a_ready, a_rvalid, a_err;
        logic [63:0] a_rdata;
        a_ready  = (which == 0) ? ready0  : ready1;
        a_rvalid = (which == 0) ? rvalid0 : rvalid1;
        a_rdata  = (which == 0) ? rdata0  : rdata1;
        a_err    = (which == 0) ? err0    : err1;
        cmp(nm, "ready",  {63'd0, a_ready},  {63'd0, e_ready});
        cmp(nm, "rvalid", {63'd0, a_rvalid}, {63'd0, e_rvalid});
        cmp(nm, "rdata",  a_rdata,           e_rdata);
        cmp(nm, "err",    {63'd0, a_err},    {63'd0, e_err});
    endtask

    function automatic logic [63:0] pat(input logic [63:0] base, input int k);
        return base + 64'(k);
    endfunction

    initial begin
        int n;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 64'd0;

        // rst rd wr addr wdata | ready rvalid rdata err
        add(1, 0, 0, 32'h0000_0000, 64'd0, 0, 0, 64'd0, 0);   // reset
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_1040, W1,    1, 0, 64'd0, 0);   // write line 0x82
        add(0, 0, 1, 32'h0000_1040, W2,    1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_1040, W3,    1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_1040, W4,    1, 0, 64'd0, 0);
        add(0, 1, 0, 32'h0000_1040, 64'd0, 0, 0, 64'd0, 0);   // read, cycle t
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W1,    0);   // t+2
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W2,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W3,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W4,    0);   // t+5
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_2040, A1,    1, 0, 64'd0, 0);   // write line 2 (aliased)
        add(0, 0, 1, 32'h0000_2040, B1,    1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_2040, C1,    1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_2040, D1,    1, 0, 64'd0, 0);
        add(0, 1, 0, 32'h0000_0047, 64'd0, 0, 0, 64'd0, 0);   // read line 2, offset bits set
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, A1,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, B1,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, C1,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, D1,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 0);
        add(0, 1, 0, 32'h0000_1040, 64'd0, 0, 0, 64'd0, 0);   // held read, 3 cycles
        add(0, 1, 0, 32'h0000_1040, 64'd0, 0, 1, W1,    1);
        add(0, 1, 0, 32'h0000_1040, 64'd0, 0, 1, W2,    1);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W3,    1);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W4,    1);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 1);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 1);   // no second burst
        add(1, 0, 0, 32'h0000_0000, 64'd0, 0, 0, 64'd0, 0);   // reset clears err
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_00A0, O0,    1, 0, 64'd0, 0);   // old contents of line 5
        add(0, 0, 1, 32'h0000_00A0, O1,    1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_00A0, O2,    1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_00A0, O3,    1, 0, 64'd0, 0);
        add(0, 0, 1, 32'h0000_00A0, N0,    1, 0, 64'd0, 0);   // truncated write
        add(0, 0, 1, 32'h0000_00A0, N1,    1, 0, 64'd0, 0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 1);
        add(0, 1, 0, 32'h0000_00A0, 64'd0, 0, 0, 64'd0, 1);   // accepted: FSM was IDLE
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, N0,    1);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, N1,    1);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, O2,    1);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, O3,    1);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 1);
        add(1, 0, 0, 32'h0000_0000, 64'd0, 0, 0, 64'd0, 0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 0);
        add(0, 1, 0, 32'h0000_1040, 64'd0, 0, 0, 64'd0, 0);   // read, reset during beat 1
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W1,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W2,    0);
        add(1, 0, 0, 32'h0000_0000, 64'd0, 0, 0, 64'd0, 0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 0);
        add(0, 1, 0, 32'h0000_1040, 64'd0, 0, 0, 64'd0, 0);   // new read completes
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W1,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W2,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W3,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 0, 1, W4,    0);
        add(0, 0, 0, 32'h0000_0000, 64'd0, 1, 0, 64'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("vec%0d", i), 0, tbl[i].ready, tbl[i].rvalid, tbl[i].rdata, tbl[i].err);
        end

        // READ_LATENCY=1: back-to-back reads of lines 3 and 4 on dut1.
        drive(1, 0, 0, 32'h0, 64'd0);
        drive(0, 0, 0, 32'h0, 64'd0);
        for (int k = 0; k < 4; k++) drive(0, 0, 1, 32'h0000_0060, pat(64'h0300_0000_0000_0000, k));
        for (int k = 0; k < 4; k++) drive(0, 0, 1, 32'h0000_0080, pat(64'h0400_0000_0000_0000, k));
        drive(0, 1, 0, 32'h0000_0060, 64'd0);
        chk("l1_line3_b0", 1, 1'b0, 1'b1, pat(64'h0300_0000_0000_0000, 0), 1'b0);
        for (int k = 1; k < 4; k++) begin
            drive(0, 0, 0, 32'h0, 64'd0);
            chk($sformatf("l1_line3_b%0d", k), 1, 1'b0, 1'b1, pat(64'h0300_0000_0000_0000, k), 1'b0);
        end
        drive(0, 0, 0, 32'h0, 64'd0);
        chk("l1_gap", 1, 1'b1, 1'b0, 64'd0, 1'b0);
        drive(0, 1, 0, 32'h0000_0080, 64'd0);
        chk("l1_line4_b0", 1, 1'b0, 1'b1, pat(64'h0400_0000_0000_0000, 0), 1'b0);
        for (int k = 1; k < 4; k++) begin
            drive(0, 0, 0, 32'h0, 64'd0);
            chk($sformatf("l1_line4_b%0d", k), 1, 1'b0, 1'b1, pat(64'h0400_0000_0000_0000, k), 1'b0);
        end
        drive(0, 0, 0, 32'h0, 64'd0);
        chk("l1_end", 1, 1'b1, 1'b0, 64'd0, 1'b0);

        // dut0: bounded wait for the first beat of a read of line 4.
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 32'h0, 64'd0);
        drive(0, 1, 0, 32'h0000_0080, 64'd0);
        n = 1;
        while (rvalid0 !== 1'b1 && n < 8) begin
            drive(0, 0, 0, 32'h0, 64'd0);
            n++;
        end
        cmp("l2_latency", "cycles", 64'(n), 64'd2);
        cmp("l2_latency", "rdata", rdata0, pat(64'h0400_0000_0000_0000, 0));
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 32'h0, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
